bit_serial_mac_acc: RTL
=======================

// Module: bit_serial_mac_acc
// PURPOSE
//  Parametrised bit-serial signed MAC: multiplies A_W-bit activation by a runtime-selectable 1..W_W-bit
//  two's-complement weight, one weight bit per clk, LSB first, final (sign) bit subtracted.
//  Accumulates successive products into an ACC_W-bit accumulator; emits the sum on a valid/ready port.
//  Sits between the operand fetch stage and the output buffer of a PE row; successor to the 8x8 MAC_Unit.
// PARAMETERS
//  A_W    8   activation width (signed)
//  W_W    8   maximum weight width (signed)
//  ACC_W  24  accumulator width, >= A_W+W_W
// PORTS
//  clk        in   1            clock, rising edge
//  rstn       in   1            asynchronous active-low reset
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            block can accept operand beat
//  act        in   A_W          signed activation
//  wgt        in   W_W          weight; only bits [wbits-1:0] used, bit wbits-1 is the sign
//  wbits      in   $clog2(W_W)+1  weight precision; 0 or >W_W means W_W
//  acc_clr    in   1            beat starts a new sum (acc taken as 0 before adding)
//  last       in   1            beat closes the sum; result emitted after it
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  ACC_W        signed accumulated sum
//  out_ovf    out  1            sticky: signed overflow occurred in this sum
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, acc=0, ovf=0, bit counter=0, in_ready=1, out_valid=0,
//   out_data=0, out_ovf=0, busy=0. Reset mid-RUN/OUT aborts the op with no residual state.
//  FSM IDLE -> RUN -> (IDLE | OUT) -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, latch act, wgt, n=eff(wbits), acc_clr, last;
//     clear partial product P and counter k; if acc_clr, clear acc and ovf; go RUN.
//   RUN: in_ready=0; one cycle per weight bit, k=0..n-1.
//     k<n-1: P += wgt[k] ? sext(act)<<k : 0.   k=n-1: P -= wgt[k] ? sext(act)<<k : 0.
//     In cycle k=n-1, acc <= acc + sext(P_final) (mod 2^ACC_W); ovf |= signed overflow of that add.
//     Next: last ? OUT : IDLE.  n=1: single cycle, product = -act*wgt[0].
//   OUT: out_valid=1, out_data=acc, out_ovf=ovf, held stable while out_ready=0.
//     On out_ready: acc=0, ovf=0, go IDLE. in_ready=0 throughout.
//  Latency: accept at cycle 0; RUN cycles 1..n; out_valid first high in cycle n+1.
//  Throughput: n+1 cycles per non-last beat (in_ready drops during RUN).
//  acc_clr and last may both be set (single-product sum). acc_clr=0 after a result: acc already 0.
//  P width A_W+W_W; result exact for all n, including act=-2^(A_W-1), wgt sign-only.
//  Inputs other than in_valid/out_ready are ignored outside the IDLE accept cycle.
// STRUCTURE
//  Shared header bs_mac_defs.vh: state encodings (IDLE/RUN/OUT), eff-precision function.
//  One sub-module: bs_serial_mult (act/wgt/n in, start, done, signed product out; owns P, k).
//  Top holds FSM, accumulator, overflow detect, handshake. Adders may reuse ADDER.
// TESTING
//  1 A=0x67,W=0x0A,wbits=8,clr,last -> out_data=1030 (0x000406), out_valid in cycle 9, ovf=0.
//  2 A=0xB4,W=0x40,clr,last -> -4864 (0xFFED00); A=0x80,W=0x80 -> 16384 (0x004000).
//  3 wbits=4, A=0x3F, W=0xE1 (low nibble=+1) -> 63, out_valid in cycle 5; wbits=0 behaves as 8.
//  4 Beats (0x67,0x0A,clr),(0x3F,0xE1),(0xA9,0xB5,last) -> 1030-1953+6525=5602 (0x0015E2).
//  5 out_ready low 5 cycles in OUT -> out_valid/out_data stable, in_ready=0; ACC_W=16 with
//    2x(0x80*0x80) -> out_data=0x8000, out_ovf=1; next sum with clr -> out_ovf=0.
//  6 rstn low in RUN cycle 3 -> all outputs reset immediately; next op from test 1 yields 1030.

Source files
------------

// File: rtl/bit_serial_mac_acc_pkg.sv
// Shared types and helpers for the bit-serial MAC.
// FSM state encoding and effective weight precision.
package bit_serial_mac_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // 0 or out-of-range precision selects full width
  function automatic int eff_bits(
    input int wb,
    input int max_w
  );
    return (wb == 0 || wb > max_w) ? max_w : wb;
  endfunction

endpackage

// File: rtl/bit_serial_mac_acc_mult.sv
// Bit-serial signed multiplier, one weight bit per step, LSB first.
// Ports: start loads act/wgt/n; step advances; done+prod on last bit.
module bit_serial_mac_acc_mult
  import bit_serial_mac_acc_pkg::*;
#(
  parameter int A_W = 8,
  parameter int W_W = 8,
  parameter int NB  = $clog2(W_W) + 1,
  parameter int PW  = A_W + W_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          step,
  input  logic [A_W-1:0] act_i,
  input  logic [W_W-1:0] wgt_i,
  input  logic [NB-1:0]  n_i,
  output logic          done,
  output logic [PW-1:0] prod
);

  localparam int KW = (W_W > 1) ? $clog2(W_W) : 1;

  logic [A_W-1:0] act_q, act_d;
  logic [W_W-1:0] wgt_q, wgt_d;
  logic [NB-1:0]  n_q, n_d;
  logic [KW-1:0]  k_q, k_d;
  logic [PW-1:0]  p_q, p_d;

  logic [PW-1:0] act_x;
  logic [PW-1:0] term;
  logic [PW-1:0] p_sum;
  logic          last_bit;

  assign act_x    = {{W_W{act_q[A_W-1]}}, act_q};
  assign term     = wgt_q[k_q] ? (act_x << k_q) : '0;
  assign last_bit = (NB'(k_q) == (n_q - NB'(1)));
  // sign bit of the weight carries negative weight
  assign p_sum    = last_bit ? (p_q - term) : (p_q + term);
  assign done     = step && last_bit;
  assign prod     = p_sum;

  always_comb begin
    act_d = act_q;
    wgt_d = wgt_q;
    n_d   = n_q;
    k_d   = k_q;
    p_d   = p_q;
    if (start) begin
      act_d = act_i;
      wgt_d = wgt_i;
      n_d   = n_i;
      k_d   = '0;
      p_d   = '0;
    end else if (step) begin
      p_d = p_sum;
      k_d = last_bit ? '0 : k_q + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q <= '0;
      wgt_q <= '0;
      n_q   <= '0;
      k_q   <= '0;
      p_q   <= '0;
    end else begin
      act_q <= act_d;
      wgt_q <= wgt_d;
      n_q   <= n_d;
      k_q   <= k_d;
      p_q   <= p_d;
    end
  end

endmodule

// File: rtl/bit_serial_mac_acc.sv
// Bit-serial signed MAC with accumulator and valid/ready result port.
// Ports: in_* operand beat, out_* result, busy = not idle.
module bit_serial_mac_acc
  import bit_serial_mac_acc_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_W-1:0]         act,
  input  logic [W_W-1:0]         wgt,
  input  logic [$clog2(W_W):0]   wbits,
  input  logic                   acc_clr,
  input  logic                   last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int NB = $clog2(W_W) + 1;
  localparam int PW = A_W + W_W;

  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;

  logic          start;
  logic          step;
  logic          done;
  logic [PW-1:0] prod;
  logic [NB-1:0] n_eff;

  logic signed [PW-1:0] prod_s;
  logic [ACC_W-1:0]     prod_x;
  logic [ACC_W-1:0]     sum;
  logic                 add_ovf;

  assign n_eff  = NB'(eff_bits(int'(wbits), W_W));
  assign prod_s = prod;
  assign prod_x = ACC_W'(prod_s);
  assign sum    = acc_q + prod_x;
  // same-sign operands, different-sign result
  assign add_ovf = (acc_q[ACC_W-1] == prod_x[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);

  bit_serial_mac_acc_mult #(
    .A_W (A_W),
    .W_W (W_W)
  ) u_mult (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .step  (step),
    .act_i (act),
    .wgt_i (wgt),
    .n_i   (n_eff),
    .done  (done),
    .prod  (prod)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    start   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          start   = 1'b1;
          last_d  = last;
          state_d = S_RUN;
          if (acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (done) begin
          acc_d   = sum;
          ovf_d   = ovf_q | add_ovf;
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule
